decoder_3x8_dispatch: RTL and testbench
=======================================

# decoder_3x8_dispatch

Registered 3-to-8 decoder with request bookkeeping, the inverse of the 8-to-3 priority encoder. It accepts a 3-bit line code over a valid/ready handshake and sets the matching bit of an 8-bit one-hot pending vector `y`. Each pending bit holds until its consumer acknowledges it. It sits between an encoded request source and the per-line consumers. It also keeps an acceptance counter and a new-request strobe for monitoring.

## Interface
- `CNT_W`, default 8: width of the acceptance counter `acc_cnt`.
- `clk`  input  1  system clock; all state updates on posedge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `i`  input  3  line code to decode (0..7).
- `i_valid`  input  1  `i` is valid this cycle.
- `i_ready`  output  1  block can accept `i` this cycle (combinational).
- `ack`  input  8  per-line acknowledge; `ack[k]` clears `y[k]`.
- `y`  output  8  pending vector; bit k set means request k is outstanding.
- `busy`  output  1  `|y` (combinational from the register).
- `new_strb`  output  1  one-cycle pulse the cycle after any acceptance.
- `acc_cnt`  output  CNT_W  number of accepted codes, wraps modulo 2^CNT_W.
- `ovf`  output  1  sticky duplicate-request flag (present only with the macro).
- `ovf_clr`  input  1  clears `ovf` (present only with the macro).

## Operation
- Acceptance happens on a posedge where `i_valid & i_ready`.
- Decode: on acceptance, `y[i]` <= 1. All other bits are affected only by their own `ack`.
- Clear: `ack[k]` at a posedge sets `y[k]` <= 0, unless line k is accepted on the same edge, in which case set wins and `y[k]` stays 1.
- Multiple `ack` bits may be high together; each clears its own bit independently.
- `ack[k]` while `y[k]`=0 is ignored.
- `i_ready` without the macro: `~y[i] | ack[i]`. A code for a pending, unacknowledged line is held off.
- `acc_cnt` increments by 1 per acceptance and wraps from 2^CNT_W-1 to 0.
- `new_strb` is a registered copy of the acceptance condition.
- `i_valid` low: no state change except `ack` clears and `new_strb` dropping to 0.
- `i` is sampled only when `i_valid`=1; X on `i` while `i_valid`=0 must not corrupt state.

## Timing
- Reset (asynchronous assert, synchronous release at the next posedge):
  - `y`=8'h00, `busy`=0, `new_strb`=0, `acc_cnt`=0, `ovf`=0.
  - `i_ready`=1 during and after reset.
- Latency: a code accepted at edge N appears in `y` and `busy` after edge N, and `new_strb` is high for the cycle following edge N.
- A cleared bit (ack at edge N) reads 0 after edge N. The same line can be re-accepted at edge N if `ack` and `i` coincide.
- Back-to-back acceptance of distinct codes every cycle gives one new `y` bit per cycle and `new_strb` held high.
- Reset mid-operation clears all pending bits and the counter at once, regardless of in-flight `ack` or `i_valid`.

## Configuration
- Macro: `DECODER_3X8_DISPATCH_OVF_EN`.
- Defined:
  - `i_ready` is tied to 1.
  - A code accepted while `y[i]`=1 and `ack[i]`=0 leaves `y` unchanged, sets `ovf` to 1 (sticky), and still increments `acc_cnt` and pulses `new_strb`.
  - `ovf_clr` at a posedge clears `ovf`. If a duplicate arrives on the same edge, `ovf` stays 1.
  - A same-edge `ack[k]` plus code k is not an overflow.
- Undefined: `ovf` and `ovf_clr` ports are absent, and duplicates are back-pressured through `i_ready`.

## Test plan
- Reset: hold `rst_n`=0 with `i_valid`=1 and `i`=3 -> `y`=8'h00, `acc_cnt`=0, `i_ready`=1. Release, then one edge -> `y`=8'h08, `new_strb`=1 for one cycle, `acc_cnt`=1.
- Sweep: `i`=0..7 on consecutive cycles with `i_valid`=1 -> `y` grows 01,03,07,…,FF; `new_strb` high for 8 cycles; `acc_cnt`=8.
- Ack: with `y`=8'hFF, drive `ack`=8'hA5 for one edge -> `y`=8'h5A, `busy`=1. Then `ack`=8'h5A -> `y`=8'h00, `busy`=0.
- Duplicate, macro off: `y`=8'h04, `i`=2, `i_valid`=1 -> `i_ready`=0 and `y`, `acc_cnt` unchanged. Assert `ack`=8'h04 on the same cycle -> accepted, `y` stays 8'h04, `acc_cnt`+1.
- Duplicate, macro on: `y`=8'h04, `i`=2 -> `ovf`=1, `y`=8'h04, `acc_cnt`+1. Then `ovf_clr`=1 -> `ovf`=0.
- Wrap and async reset: `CNT_W`=4, 17 acceptances with an ack each cycle -> `acc_cnt`=1. Pulse `rst_n` low between clock edges -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/decoder_3x8_dispatch_if.sv
// Request-side bus of decoder_3x8_dispatch: encoded line code in, one-hot pending vector out.
// With DECODER_3X8_DISPATCH_OVF_EN defined the bus also carries ovf / ovf_clr.
interface decoder_3x8_dispatch_if #(
    parameter int CNT_W = 8
);
    // Handshake: a code on i is taken on a posedge where i_valid & i_ready;
    // i_ready is combinational and i is ignored whenever i_valid is low.
    logic [2:0]       i;
    logic             i_valid;
    logic             i_ready;
    logic [7:0]       ack;
    logic [7:0]       y;
    logic             busy;
    logic             new_strb;
    logic [CNT_W-1:0] acc_cnt;
`ifdef DECODER_3X8_DISPATCH_OVF_EN
    logic             ovf;
    logic             ovf_clr;

    modport master (
        output i, i_valid, ack, ovf_clr,
        input  i_ready, y, busy, new_strb, acc_cnt, ovf
    );
    modport slave (
        input  i, i_valid, ack, ovf_clr,
        output i_ready, y, busy, new_strb, acc_cnt, ovf
    );
`else
    modport master (
        output i, i_valid, ack,
        input  i_ready, y, busy, new_strb, acc_cnt
    );
    modport slave (
        input  i, i_valid, ack,
        output i_ready, y, busy, new_strb, acc_cnt
    );
`endif
endinterface

// File: rtl/decoder_3x8_dispatch.sv
// Registered 3-to-8 decoder keeping one pending bit per line until acknowledged.
// DECODER_3X8_DISPATCH_OVF_EN: never back-pressure, flag duplicates in a sticky ovf bit.
module decoder_3x8_dispatch #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_3x8_dispatch_if.slave bus
);
    logic [7:0]       y_q;
    logic [7:0]       set_vec;
    logic [7:0]       y_next;
    logic             accept;
    logic             strb_q;
    logic [CNT_W-1:0] cnt_q;

    assign accept = bus.i_valid & bus.i_ready;

    always_comb begin
        set_vec = 8'h00;
        if (accept) begin
            set_vec[bus.i] = 1'b1;
        end
    end

    // Set is OR-ed after the clear mask so a same-edge ack and code keep the bit.
    assign y_next = (y_q & ~bus.ack) | set_vec;

`ifdef DECODER_3X8_DISPATCH_OVF_EN
    logic ovf_q;
    logic dup;

    assign bus.i_ready = 1'b1;
    assign dup         = accept & y_q[bus.i] & ~bus.ack[bus.i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (dup) begin
            ovf_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.i_ready = ~y_q[bus.i] | bus.ack[bus.i];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q    <= 8'h00;
            strb_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            y_q    <= y_next;
            strb_q <= accept;
            if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.y        = y_q;
    assign bus.busy     = |y_q;
    assign bus.new_strb = strb_q;
    assign bus.acc_cnt  = cnt_q;
endmodule

// File: tb/tb_decoder_3x8_dispatch.sv
// Bench for decoder_3x8_dispatch: directed vector table, counter wrap, async reset,
// then randomized traffic checked against a per-line pending model.
module tb_decoder_3x8_dispatch;
    localparam int CNT_W = 4;
`ifdef DECODER_3X8_DISPATCH_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    decoder_3x8_dispatch_if #(.CNT_W(CNT_W)) bus ();

    decoder_3x8_dispatch #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one flag per line, a plain integer counter.
    bit m_pend[8];
    int m_cnt;
    bit m_strb;
    bit m_ovf;

    function automatic logic [7:0] m_y();
        logic [7:0] v = 8'h00;
        for (int k = 0; k < 8; k++) if (m_pend[k]) v[k] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_pend[k] = 1'b0;
        m_cnt  = 0;
        m_strb = 1'b0;
        m_ovf  = 1'b0;
    endtask

    function automatic bit m_ready(input logic [2:0] c, input logic [7:0] a);
        return OVF_EN || !m_pend[c] || a[c];
    endfunction

    task automatic model_step(input logic v, input logic [2:0] c, input logic [7:0] a,
                              input logic clr);
        bit acc;
        bit dup;
        acc = v && m_ready(c, a);
        dup = acc && m_pend[c] && !a[c];
        for (int k = 0; k < 8; k++) if (a[k]) m_pend[k] = 1'b0;
        if (acc) m_pend[c] = 1'b1;
        if (acc) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_strb = acc;
        if (OVF_EN) begin
            if (dup) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] ey;
        ey = m_y();
        chk({tag, ".y"}, 32'(bus.y), 32'(ey));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(ey != 8'h00));
        chk({tag, ".new_strb"}, 32'(bus.new_strb), 32'(m_strb));
        chk({tag, ".acc_cnt"}, 32'(bus.acc_cnt), 32'(m_cnt));
`ifdef DECODER_3X8_DISPATCH_OVF_EN
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
`endif
    endtask

    task automatic set_inputs(input logic v, input logic [2:0] c, input logic [7:0] a,
                              input logic clr);
        bus.i_valid = v;
        bus.i       = c;
        bus.ack     = a;
`ifdef DECODER_3X8_DISPATCH_OVF_EN
        bus.ovf_clr = clr;
`else
        if (clr) begin end
`endif
    endtask

    // One cycle: check state at negedge, drive, check i_ready, step the model at posedge.
    task automatic drive(input logic v, input logic [2:0] c, input logic [7:0] a,
                         input logic clr);
        @(negedge clk);
        check_state("state");
        set_inputs(v, c, a, clr);
        #1;
        chk("i_ready", 32'(bus.i_ready), 32'(m_ready(c, a)));
        @(posedge clk);
        model_step(v, c, a, clr);
    endtask

    typedef struct {
        logic       v;
        logic [2:0] c;
        logic [7:0] a;
        logic       clr;
        logic [7:0] ey;
        logic       es;
        int         ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [2:0] c, input logic [7:0] a,
                                input logic clr, input logic [7:0] ey, input logic es,
                                input int ec);
        vec_t r;
        r.v = v; r.c = c; r.a = a; r.clr = clr; r.ey = ey; r.es = es; r.ec = ec;
        return r;
    endfunction

    initial begin
        // Directed table; starts from y=08, acc_cnt=1 after the reset sequence.
        tbl.push_back(mk(1'b0, 3'd0, 8'h08, 1'b0, 8'h00, 1'b0, 1));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1'b1, 3'(k), 8'h00, 1'b0, 8'((1 << (k + 1)) - 1), 1'b1, 2 + k));
        tbl.push_back(mk(1'b0, 3'd0, 8'hA5, 1'b0, 8'h5A, 1'b0, 9));
        tbl.push_back(mk(1'b0, 3'd0, 8'h5A, 1'b0, 8'h00, 1'b0, 9));
        tbl.push_back(mk(1'b1, 3'd2, 8'h00, 1'b0, 8'h04, 1'b1, 10));
        tbl.push_back(mk(1'b1, 3'd2, 8'h00, 1'b0, 8'h04, OVF_EN, OVF_EN ? 11 : 10));
        tbl.push_back(mk(1'b1, 3'd2, 8'h04, 1'b0, 8'h04, 1'b1, OVF_EN ? 12 : 11));
        tbl.push_back(mk(1'b0, 3'd0, 8'h00, 1'b1, 8'h04, 1'b0, OVF_EN ? 12 : 11));

        // Reset held with a valid code pending on the bus.
        rst_n = 1'b0;
        set_inputs(1'b1, 3'd3, 8'h00, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.y", 32'(bus.y), 32'h00);
        chk("rst.acc_cnt", 32'(bus.acc_cnt), 32'h0);
        chk("rst.i_ready", 32'(bus.i_ready), 32'h1);
        chk("rst.new_strb", 32'(bus.new_strb), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        model_step(1'b1, 3'd3, 8'h00, 1'b0);
        #1;
        chk("rel.y", 32'(bus.y), 32'h08);
        chk("rel.new_strb", 32'(bus.new_strb), 32'h1);
        chk("rel.acc_cnt", 32'(bus.acc_cnt), 32'h1);

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].v, tbl[n].c, tbl[n].a, tbl[n].clr);
            #1;
            chk($sformatf("tbl%0d.y", n), 32'(bus.y), 32'(tbl[n].ey));
            chk($sformatf("tbl%0d.new_strb", n), 32'(bus.new_strb), 32'(tbl[n].es));
            chk($sformatf("tbl%0d.acc_cnt", n), 32'(bus.acc_cnt), 32'(tbl[n].ec));
        end

        // Counter wrap: 17 acceptances with every line acknowledged each cycle.
        @(negedge clk);
        set_inputs(1'b0, 3'd0, 8'h00, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int n = 0; n < 17; n++) drive(1'b1, 3'(n % 8), 8'hFF, 1'b0);
        #1;
        chk("wrap.acc_cnt", 32'(bus.acc_cnt), 32'h1);
        chk("wrap.y", 32'(bus.y), 32'h01);

        // Asynchronous reset between edges with traffic still on the bus.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.y", 32'(bus.y), 32'h00);
        chk("arst.busy", 32'(bus.busy), 32'h0);
        chk("arst.new_strb", 32'(bus.new_strb), 32'h0);
        chk("arst.acc_cnt", 32'(bus.acc_cnt), 32'h0);
        chk("arst.i_ready", 32'(bus.i_ready), 32'h1);
        model_reset();
        @(negedge clk);
        set_inputs(1'b0, 3'd0, 8'h00, 1'b0);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic       v;
            logic [2:0] c;
            logic [7:0] a;
            logic       clr;
            v   = ($urandom_range(0, 3) != 0);
            c   = 3'($urandom_range(0, 7));
            a   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            clr = ($urandom_range(0, 7) == 0);
            drive(v, c, a, clr);
        end
        @(negedge clk);
        check_state("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
